// File: rtl/icache_event_counters.sv
`default_nettype none
// ============================================================================
// Module      : icache_event_counters
// Description : Event counter bank for the instruction cache. Every L0 event
//               bit of every fetch port and every L1 event bit feeds its own
//               saturating counter. Counters are read or cleared through a
//               single-cycle register port (always accepted, 1-cycle response).
//
//               Counter index map (bit b of each packed event struct):
//                 L0 port p : index 5p + b
//                             b0 stall, b1 double_hit, b2 prefetch,
//                             b3 hit, b4 miss
//                 L1        : index 5*NR_FETCH_PORTS + b
//                             b0 handler_stall, b1 stall, b2 hit, b3 miss
//               Address NUM_CNT is the clear-all code.
//
// Optional    : ICACHE_EVENT_SNAPSHOT_EN
//               Adds snapshot_i and a shadow bank. A snapshot copies the
//               pre-increment, pre-clear live values into the shadow bank;
//               reads then return shadow values while clears still act on
//               the live counters.
//
// Ports       : clk_i        clock
//               rst_i        synchronous active-high reset
//               enable_i     1 = count events, 0 = freeze counting
//               l0_events_i  per-port L0 event vectors (5 bits per port)
//               l1_events_i  L1 event vector (4 bits)
//               snapshot_i   (optional) capture live counters into shadow
//               req_i        register access request
//               we_i         1 = clear, 0 = read
//               addr_i       counter index or clear-all code
//               rdata_o      read data
//               rvalid_o     response valid
//               rerr_o       address error, qualified by rvalid_o
//               sat_o        sticky: some counter saturated
//
// Revision    : 1.0 - initial release
// ============================================================================
module icache_event_counters #(
  parameter int NR_FETCH_PORTS = 2,
  parameter int CNT_W          = 32,
  localparam int NUM_CNT       = 5 * NR_FETCH_PORTS + 4,
  localparam int ADDR_W        = $clog2(NUM_CNT + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        enable_i,
  input  logic [5*NR_FETCH_PORTS-1:0] l0_events_i,
  input  logic [3:0]                  l1_events_i,
`ifdef ICACHE_EVENT_SNAPSHOT_EN
  input  logic                        snapshot_i,
`endif
  input  logic                        req_i,
  input  logic                        we_i,
  input  logic [ADDR_W-1:0]           addr_i,
  output logic [CNT_W-1:0]            rdata_o,
  output logic                        rvalid_o,
  output logic                        rerr_o,
  output logic                        sat_o
);

  localparam logic [ADDR_W-1:0] c_clr_all_addr = ADDR_W'(NUM_CNT);

  // L0 ports occupy the low indices, L1 sits directly above them, so a plain
  // concatenation yields the counter index map.
  logic [NUM_CNT-1:0] w_events;
  assign w_events = {l1_events_i, l0_events_i};

  logic             w_rd_req;
  logic             w_wr_req;
  logic             w_in_range;
  logic             w_clr_all;
  logic [NUM_CNT-1:0] w_clr;
  logic [NUM_CNT-1:0] w_inc;
  logic [NUM_CNT-1:0] w_at_max;
  logic [NUM_CNT-1:0] w_sat_hit;
  logic [CNT_W-1:0] w_rd_val;

  logic [CNT_W-1:0] r_cnt [NUM_CNT];
  logic             r_sat;
  logic [CNT_W-1:0] r_rdata;
  logic             r_rvalid;
  logic             r_rerr;

  assign w_rd_req   = req_i & ~we_i;
  assign w_wr_req   = req_i & we_i;
  assign w_in_range = (addr_i < c_clr_all_addr);
  assign w_clr_all  = w_wr_req & (addr_i == c_clr_all_addr);

  // Per-counter control. A clear on a counter suppresses its event for that
  // cycle, including the saturation report it would otherwise raise.
  generate
    for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt_ctl
      assign w_clr[i]     = w_clr_all | (w_wr_req & (addr_i == ADDR_W'(i)));
      assign w_inc[i]     = enable_i & w_events[i];
      assign w_at_max[i]  = &r_cnt[i];
      assign w_sat_hit[i] = w_inc[i] & w_at_max[i] & ~w_clr[i];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_clr[i]) begin
          r_cnt[i] <= '0;
        end else if (w_inc[i] && !w_at_max[i]) begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sat <= 1'b0;
    end else if (w_clr_all) begin
      r_sat <= 1'b0;
    end else if (|w_sat_hit) begin
      r_sat <= 1'b1;
    end
  end

`ifdef ICACHE_EVENT_SNAPSHOT_EN
  logic [CNT_W-1:0] r_shadow [NUM_CNT];

  // Captures the current register contents, i.e. values before this cycle's
  // increments and clears take effect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (snapshot_i) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        r_shadow[i] <= r_cnt[i];
      end
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (addr_i == ADDR_W'(i)) begin
        w_rd_val = r_shadow[i];
      end
    end
  end
`else
  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (addr_i == ADDR_W'(i)) begin
        w_rd_val = r_cnt[i];
      end
    end
  end
`endif

  // Response stage: reads return the pre-increment value of the request
  // cycle; clears and bad addresses return zero. rdata holds between
  // responses, rerr is only meaningful alongside rvalid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rerr   <= 1'b0;
    end else begin
      r_rvalid <= req_i;
      if (req_i) begin
        r_rdata <= (w_rd_req && w_in_range) ? w_rd_val : '0;
        r_rerr  <= w_rd_req ? ~w_in_range : (addr_i > c_clr_all_addr);
      end else begin
        r_rerr  <= 1'b0;
      end
    end
  end

  assign rdata_o  = r_rdata;
  assign rvalid_o = r_rvalid;
  assign rerr_o   = r_rerr;
  assign sat_o    = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_icache_event_counters.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_event_counters
// Description : Self-checking bench for icache_event_counters. Two instances
//               share all stimulus: a 32-bit counter build and a 4-bit build
//               that reaches saturation quickly. A bench-side model computes
//               the expected response of every request, queues it, and the
//               queue is compared against the DUT outputs one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_event_counters;

  localparam int NUM = 14;
`ifdef ICACHE_EVENT_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, req, we, snap;
  logic [9:0]  l0;
  logic [3:0]  l1;
  logic [3:0]  addr;

  logic [31:0] rd0;
  logic [3:0]  rd1;
  logic        rv0, rv1, er0, er1, sat0, sat1;

  icache_event_counters #(.NR_FETCH_PORTS(2), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en),
    .l0_events_i(l0), .l1_events_i(l1),
`ifdef ICACHE_EVENT_SNAPSHOT_EN
    .snapshot_i(snap),
`endif
    .req_i(req), .we_i(we), .addr_i(addr),
    .rdata_o(rd0), .rvalid_o(rv0), .rerr_o(er0), .sat_o(sat0)
  );

  icache_event_counters #(.NR_FETCH_PORTS(2), .CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .enable_i(en),
    .l0_events_i(l0), .l1_events_i(l1),
`ifdef ICACHE_EVENT_SNAPSHOT_EN
    .snapshot_i(snap),
`endif
    .req_i(req), .we_i(we), .addr_i(addr),
    .rdata_o(rd1), .rvalid_o(rv1), .rerr_o(er1), .sat_o(sat1)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        err;
  } resp_t;

  resp_t       q[$];
  logic [31:0] m_cnt [2][NUM];
  logic [31:0] m_shd [2][NUM];
  logic        m_sat [2];
  logic [31:0] m_last[2];
  logic [31:0] m_max [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: model the cycle with the inputs currently applied,
  // advance the clock, then compare the DUT outputs.
  task automatic step();
    resp_t       e;
    logic [13:0] ev;
    logic        clr, hit;
    ev = {l1, l0};
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < NUM; i++) begin
          m_cnt[k][i] = 0;
          m_shd[k][i] = 0;
        end
        m_sat[k]  = 1'b0;
        m_last[k] = 0;
      end
      q.delete();
    end else begin
      if (req) begin
        e.d0 = 0; e.d1 = 0; e.err = 1'b0;
        if (!we) begin
          if (addr < NUM) begin
            e.d0 = SNAP_EN ? m_shd[0][addr] : m_cnt[0][addr];
            e.d1 = SNAP_EN ? m_shd[1][addr] : m_cnt[1][addr];
          end else begin
            e.err = 1'b1;
          end
        end else begin
          e.err = (addr > NUM);
        end
        q.push_back(e);
      end
      for (int k = 0; k < 2; k++) begin
        hit = 1'b0;
        for (int i = 0; i < NUM; i++) begin
          if (SNAP_EN && snap) m_shd[k][i] = m_cnt[k][i];
          clr = req && we && ((addr == i) || (addr == NUM));
          if (clr) begin
            m_cnt[k][i] = 0;
          end else if (en && ev[i]) begin
            if (m_cnt[k][i] == m_max[k]) hit = 1'b1;
            else m_cnt[k][i] = m_cnt[k][i] + 1;
          end
        end
        if (req && we && addr == NUM) m_sat[k] = 1'b0;
        else if (hit) m_sat[k] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("rvalid32", 32'(rv0), 32'd1);
      chk("rvalid4",  32'(rv1), 32'd1);
      chk("rdata32",  rd0, e.d0);
      chk("rdata4",   32'(rd1), e.d1);
      chk("rerr32",   32'(er0), 32'(e.err));
      chk("rerr4",    32'(er1), 32'(e.err));
      m_last[0] = e.d0;
      m_last[1] = e.d1;
    end else begin
      chk("idle_rvalid32", 32'(rv0), 32'd0);
      chk("idle_rvalid4",  32'(rv1), 32'd0);
      chk("hold_rdata32",  rd0, m_last[0]);
      chk("hold_rdata4",   32'(rd1), m_last[1]);
    end
    chk("sat32", 32'(sat0), 32'(m_sat[0]));
    chk("sat4",  32'(sat1), 32'(m_sat[1]));
  endtask

  task automatic rd(input int a);
    req = 1'b1; we = 1'b0; addr = 4'(a);
    step();
    req = 1'b0;
  endtask

  task automatic clr(input int a);
    req = 1'b1; we = 1'b1; addr = 4'(a);
    step();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    m_max[0] = 32'hFFFF_FFFF;
    m_max[1] = 32'd15;
    rst = 1'b1; en = 1'b0; req = 1'b0; we = 1'b0; snap = 1'b0;
    l0 = '0; l1 = '0; addr = '0;

    // Reset state
    idle(2);
    rst = 1'b0;
    idle(1);

    // Port 1 l0_hit (index 8) for 7 cycles
    en = 1'b1;
    l0[8] = 1'b1;
    idle(7);
    l0 = '0;
    rd(8);
    idle(1);

    // All 14 events for 3 cycles, counting frozen in the middle one
    clr(14);
    l0 = '1; l1 = '1;
    idle(1);
    en = 1'b0;
    idle(1);
    en = 1'b1;
    idle(1);
    l0 = '0; l1 = '0;
    for (int a = 0; a < NUM; a++) rd(a);
    idle(1);

    // Saturation via l1_miss (index 13)
    clr(14);
    l1[3] = 1'b1;
    idle(20);
    l1 = '0;
    rd(13);
    clr(14);
    rd(13);
    rd(0);
    idle(1);

    // Clear on index 3 while l0_hit and l0_miss of port 0 are active
    l0[3] = 1'b1;
    idle(3);
    l0[4] = 1'b1;
    clr(3);
    l0 = '0;
    rd(3);
    rd(4);
    rd(15);
    clr(15);
    rd(4);
    idle(1);

    // Back-to-back reads while l0_stall of port 0 toggles
    l0[0] = 1'b1;
    rd(0);
    l0[0] = 1'b0;
    rd(1);
    l0[0] = 1'b1;
    rd(2);
    l0[0] = 1'b0;
    rd(0);
    idle(1);

    // Snapshot sequence (reads the live bank when snapshots are absent)
    clr(14);
    l0[3] = 1'b1;
    idle(5);
    l0 = '0;
    snap = 1'b1;
    idle(1);
    snap = 1'b0;
    l0[3] = 1'b1;
    idle(4);
    l0 = '0;
    rd(3);
    snap = 1'b1;
    idle(1);
    snap = 1'b0;
    rd(3);
    // Snapshot together with clear-all keeps pre-clear values in the shadow
    snap = 1'b1;
    clr(14);
    snap = 1'b0;
    rd(3);
    idle(1);

    // Reset in the same cycle as a request drops the response
    l0[1] = 1'b1;
    idle(2);
    req = 1'b1; we = 1'b0; addr = 4'd1; rst = 1'b1;
    step();
    req = 1'b0; rst = 1'b0;
    idle(1);
    l0 = '0;
    rd(1);
    idle(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_event_counters.md
Name: icache_event_counters

Overview:
- Consumer side of the instruction-cache event strobes: counts every L0 event bit of every fetch port and every L1 event bit, each in its own counter.
- Exposes the counters through a single-cycle register read/clear port for the cluster peripheral/CSR layer.
- Sits beside the icache top level and is wired directly to its per-port L0 event vectors and its L1 event vector.

Parameters:
- NR_FETCH_PORTS, 2, number of L0 event vectors (one per fetch port).
- CNT_W, 32, counter width in bits.
- NUM_CNT, derived = 5*NR_FETCH_PORTS + 4, total number of counters.
- ADDR_W, derived = $clog2(NUM_CNT+1), address width (the extra code point is clear-all).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- enable_i  in  1  1 = count events; 0 = freeze all counters.
- l0_events_i  in  5*NR_FETCH_PORTS  per-port packed icache_l0_events_t; port p occupies bits [5p+4:5p].
- l1_events_i  in  4  packed icache_l1_events_t.
- req_i  in  1  register access request; always accepted, no grant.
- we_i  in  1  1 = clear, 0 = read.
- addr_i  in  ADDR_W  counter index, or the clear-all code.
- rdata_o  out  CNT_W  read data.
- rvalid_o  out  1  response valid.
- rerr_o  out  1  address error, qualified by rvalid_o.
- sat_o  out  1  sticky flag: some counter has saturated.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous, active-high.
- Reset values: all counters 0; rdata_o 0; rvalid_o 0; rerr_o 0; sat_o 0.
- Counter index map, with bit b taken from the packed struct (LSB = 0):
  - L0 counter index = 5p + b; b0 = l0_stall, b1 = l0_double_hit, b2 = l0_prefetch, b3 = l0_hit, b4 = l0_miss.
  - L1 counter index = 5*NR_FETCH_PORTS + b; b0 = l1_handler_stall, b1 = l1_stall, b2 = l1_hit, b3 = l1_miss.
- Counting: each cycle with enable_i=1, every counter whose event bit is 1 increments by exactly 1.
  - Events are level-sampled per cycle; a bit held high for N cycles adds N.
  - Counters are independent; any number may increment in the same cycle.
- Saturation: a counter at 2^CNT_W-1 holds that value and does not wrap.
  - An increment attempt while saturated sets sat_o.
  - sat_o clears only on reset or a clear-all.
- Read (req_i=1, we_i=0):
  - Latency 1: rvalid_o=1 in the next cycle, for exactly one cycle per request.
  - rdata_o = counter value as of the request cycle, i.e. before that cycle's increment.
  - addr_i >= NUM_CNT: rdata_o=0, rerr_o=1.
  - rdata_o holds its last value while rvalid_o=0.
- Clear (req_i=1, we_i=1):
  - addr_i < NUM_CNT: zero that counter.
  - addr_i = NUM_CNT: zero all counters and sat_o.
  - Any other address: rerr_o=1, no state change.
  - A clear also produces rvalid_o next cycle with rdata_o=0.
- Simultaneous clear and event on the same counter: clear wins; counter = 0 the next cycle and the event is dropped.
- Back-to-back requests are legal every cycle; each produces its own response.
- enable_i=0 freezes counting only; read and clear still work.
- Reset mid-operation: a pending response is dropped (rvalid_o=0 the cycle after reset).

Optional Feature:
- Macro: ICACHE_EVENT_SNAPSHOT_EN.
- When defined:
  - Adds input snapshot_i (1 bit) and a shadow bank of NUM_CNT x CNT_W registers, reset to 0.
  - snapshot_i=1 copies all live counters into the shadow bank atomically (pre-increment values of that cycle).
  - Reads return shadow values; clears act on the live counters only.
  - Snapshot and clear-all in the same cycle: the shadow captures the pre-clear values.
- When undefined: no snapshot_i port, no shadow registers; reads return live counters.

Test Plan:
- Reset, then hold l0_events_i port 1 l0_hit=1 for 7 cycles with enable_i=1; read addr 8 -> rvalid_o=1 one cycle later, rdata_o=7, rerr_o=0.
- Assert all 14 event bits (NR_FETCH_PORTS=2) for 3 cycles, with enable_i=0 during the middle cycle; read addrs 0..13 -> every counter reads 2.
- Repeatedly increment a counter with CNT_W=4 using l1_miss (addr 13) for 20 cycles -> reads 15, sat_o=1; clear-all (addr 14) -> all counters 0, sat_o=0.
- Clear addr 3 in the same cycle as an l0_miss on port 0 -> addr 3 reads 0 and addr 4 reads 1; read addr 15 -> rdata_o=0, rerr_o=1.
- Back-to-back reads of addrs 0, 1, 2 on consecutive cycles while l0_stall port 0 toggles -> three consecutive rvalid_o pulses, each carrying the pre-increment value of its request cycle.
- With ICACHE_EVENT_SNAPSHOT_EN: count 5 l0_hit on port 0, pulse snapshot_i, count 4 more, read addr 3 -> 5; pulse snapshot_i again, read -> 9.
